// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port round-robin arbiter.
// Optional burst limit is enabled with FIFO_ARB_MAX_BURST_EN.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int MAX_BURST_DEFAULT = 16;
  localparam int BURST_CNT_W       = 8;

  // Index width for a requester count; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request scanning upward from rr_last+1 with wrap.
// Implemented as rotate, priority-encode, un-rotate.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_last,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0]      idx_sum  [NUM_REQ];
  logic [ID_W:0]      idx_wrap [NUM_REQ];
  logic [ID_W-1:0]    idx      [NUM_REQ];
  logic [NUM_REQ-1:0] rotated;
  logic [ID_W-1:0]    pos;

  // rotated[gi] is the requester sitting gi+1 places after the last winner
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign idx_sum[gi]  = {1'b0, rr_last} + (ID_W+1)'(gi + 1);
      assign idx_wrap[gi] = idx_sum[gi] - NUM_REQ_W;
      assign idx[gi]      = (idx_sum[gi] >= NUM_REQ_W) ? idx_wrap[gi][ID_W-1:0]
                                                       : idx_sum[gi][ID_W-1:0];
      assign rotated[gi]  = req[idx[gi]];
    end
  endgenerate

  always_comb begin
    pos = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        pos = ID_W'(k);
      end
    end
  end

  assign winner  = idx[pos];
  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, grant locked per burst.
// Define FIFO_ARB_MAX_BURST_EN to also release the grant after MAX_BURST beats.
module fifo_wr_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_w_en,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state_t        state_reg, state_next;
  logic [ID_W-1:0]   grant_reg, grant_next;
  logic [ID_W-1:0]   rr_last_reg, rr_last_next;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              beat;
  logic              burst_limit;
  logic [DATA_W-1:0] beat_data [NUM_REQ];
  logic [DATA_W-1:0] grant_data;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req     (req_valid),
    .rr_last (rr_last_reg),
    .winner  (winner),
    .any_req (any_req)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign beat_data[gi] = req_data[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = (state_reg == LOCK) && (grant_reg == ID_W'(gi)) && !fifo_full;
    end
  endgenerate

  // Zero-cycle forward of the grantee's beat; data bus is quiet when not writing
  assign grant_data   = beat_data[grant_reg];
  assign beat         = (state_reg == LOCK) && req_valid[grant_reg] && !fifo_full;
  assign fifo_w_en    = beat;
  assign fifo_data_in = beat ? grant_data : '0;
  assign busy         = (state_reg == LOCK);
  assign grant_id     = grant_reg;

`ifdef FIFO_ARB_MAX_BURST_EN
  localparam logic [BURST_CNT_W-1:0] CNT_LAST = BURST_CNT_W'(MAX_BURST - 1);

  logic [BURST_CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

  // Counter sits at zero while idle, so every new grant starts from a clean count
  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    if (state_reg == IDLE) begin
      beat_cnt_next = '0;
    end else if (beat) begin
      beat_cnt_next = beat_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_reg <= '0;
    end else begin
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  assign burst_limit = (beat_cnt_reg == CNT_LAST);
`else
  assign burst_limit = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    rr_last_next = rr_last_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next = winner;
          state_next = LOCK;
        end
      end
      LOCK: begin
        if (beat && (req_last[grant_reg] || burst_limit)) begin
          state_next   = IDLE;
          rr_last_next = grant_reg;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      rr_last_reg <= ID_W'(NUM_REQ - 1);
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      rr_last_reg <= rr_last_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Randomized and directed bench for fifo_wr_rr_arbiter against a cycle-level behavioural model.
// Compiling with FIFO_ARB_MAX_BURST_EN also exercises the burst-limit scenario.
module tb_fifo_wr_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef FIFO_ARB_MAX_BURST_EN
  localparam int MAXB     = 4;
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam int MAXB     = 16;
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_data_in;
  logic [1:0]      grant_id;
  logic            busy;

  fifo_wr_rr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MAXB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] gap;
  } beat_t;

  beat_t      q  [N][$];
  logic [7:0] sb [N][$];
  int         grant_log[$];
  int         wr_gid[$];
  int         wr_cyc[$];
  logic [7:0] wr_dat[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit prev_busy    = 1'b0;
  bit full_next    = 1'b0;

  // Reference model: who owns the port, who was served last, beats in this grant
  bit m_busy    = 1'b0;
  int m_grant   = 0;
  int m_rr_last = N - 1;
  int m_cnt     = 0;

  function automatic logic [15:0] exp_vec();
    logic [3:0] rdy;
    logic       wen;
    logic [7:0] d;
    rdy = (m_busy && !fifo_full) ? 4'(1 << m_grant) : 4'b0000;
    wen = m_busy && !fifo_full && req_valid[m_grant];
    d   = wen ? req_data[m_grant*8 +: 8] : 8'h00;
    return {m_busy, 2'(m_grant), rdy, wen, d};
  endfunction

  function automatic logic [15:0] act_vec();
    return {busy, grant_id, req_ready, fifo_w_en, fifo_data_in};
  endfunction

  function automatic bit drained();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() != 0) return 1'b0;
    end
    return (req_valid == '0) && !m_busy;
  endfunction

  task automatic model_step();
    bit found;
    int c;
    if (rst) begin
      m_busy = 1'b0; m_grant = 0; m_rr_last = N - 1; m_cnt = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_rr_last + k) % N;
        if (!found && req_valid[c]) begin
          found = 1'b1; m_grant = c; m_busy = 1'b1; m_cnt = 0;
        end
      end
    end else if (!fifo_full && req_valid[m_grant]) begin
      m_cnt++;
      if (req_last[m_grant] || (LIMIT_EN && m_cnt >= MAXB)) begin
        m_busy = 1'b0; m_rr_last = m_grant;
      end
    end
  endtask

  task automatic push_beat(input int i, input logic [7:0] d, input logic l, input int g);
    beat_t b;
    b.data = d; b.last = l; b.gap = 8'(g);
    q[i].push_back(b);
    sb[i].push_back(d);
  endtask

  task automatic push_burst(input int i, input int n, input int gapmax);
    for (int b = 0; b < n; b++) begin
      push_beat(i, 8'($urandom), (b == n - 1), int'($urandom % (gapmax + 1)));
    end
  endtask

  // Producers hold a presented beat until it is accepted, then move to the next one
  task automatic update_producers(input logic [N-1:0] acc);
    beat_t h;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(q[i].pop_front());
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i]) begin
        if (q[i].size() > 0 && q[i][0].gap == 8'd0) begin
          h = q[i][0];
          req_valid[i]        = 1'b1;
          req_data[i*8 +: 8]  = h.data;
          req_last[i]         = h.last;
        end else begin
          if (q[i].size() > 0) begin
            h = q[i][0];
            h.gap = h.gap - 8'd1;
            q[i][0] = h;
          end
          req_data[i*8 +: 8] = 8'($urandom);
          req_last[i]        = 1'($urandom);
        end
      end
    end
  endtask

  // Called at a negedge; returns at the next negedge with new stimulus applied
  task automatic tick();
    logic [N-1:0] acc;
    acc = req_valid & req_ready;
    if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
    prev_busy = busy;
    if (fifo_w_en) begin
      wr_gid.push_back(int'(grant_id));
      wr_dat.push_back(fifo_data_in);
      wr_cyc.push_back(cyc);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    fifo_full = full_next;
    update_producers(acc);
    @(negedge clk);
  endtask

  task automatic clear_logs();
    grant_log.delete(); wr_gid.delete(); wr_dat.delete(); wr_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    push_beat(3, 8'hA5, 1'b1, 0);
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    tests_run++;
    if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    tests_run++;
    if (fifo_w_en !== 1'b0) begin tests_failed++; $display("FAIL reset_w_en: got %b expected 0", fifo_w_en); end
    tests_run++;
    if (fifo_data_in !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", fifo_data_in); end
    rst = 1'b0;
    clear_logs();
    for (int c = 0; c < 20 && !drained(); c++) begin
      tests_run++;
      if (act_vec() !== exp_vec()) begin tests_failed++; $display("FAIL reset_cycle %0d: got %h expected %h", cyc, act_vec(), exp_vec()); end
      tick();
    end
    tests_run++;
    if (!(grant_log.size() == 1 && grant_log[0] == 3)) begin
      tests_failed++; $display("FAIL reset_first_grant: got %0d grants first %0d expected 1 grant to 3", grant_log.size(), grant_log[0]);
    end
  endtask

  task automatic test_single_burst();
    logic [7:0] e [3];
    int t_valid;
    e = '{8'h11, 8'h22, 8'h33};
    t_valid = -1;
    clear_logs();
    push_beat(0, 8'h11, 1'b0, 0);
    push_beat(0, 8'h22, 1'b0, 0);
    push_beat(0, 8'h33, 1'b1, 0);
    for (int c = 0; c < 30 && !drained(); c++) begin
      if (t_valid < 0 && req_valid[0]) t_valid = cyc;
      tests_run++;
      if (act_vec() !== exp_vec()) begin tests_failed++; $display("FAIL single_cycle %0d: got %h expected %h", cyc, act_vec(), exp_vec()); end
      tick();
    end
    tests_run++;
    if (wr_dat.size() != 3) begin tests_failed++; $display("FAIL single_count: got %0d beats expected 3", wr_dat.size()); end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (wr_dat[k] !== e[k]) begin tests_failed++; $display("FAIL single_data%0d: got %h expected %h", k, wr_dat[k], e[k]); end
    end
    tests_run++;
    if (!(grant_log.size() == 1 && grant_log[0] == 0)) begin
      tests_failed++; $display("FAIL single_grant: got %0d grants first %0d expected 1 grant to 0", grant_log.size(), grant_log[0]);
    end
    tests_run++;
    if (wr_cyc[0] != t_valid + 1) begin tests_failed++; $display("FAIL single_latency: got cycle %0d expected %0d", wr_cyc[0], t_valid + 1); end
    tests_run++;
    if (wr_cyc[2] != t_valid + 3) begin tests_failed++; $display("FAIL single_last_beat: got cycle %0d expected %0d", wr_cyc[2], t_valid + 3); end
  endtask

  task automatic test_round_robin();
    int eo [5];
    eo = '{0, 1, 2, 3, 0};
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) push_beat(i, 8'($urandom), 1'b1, 0);
    push_beat(0, 8'($urandom), 1'b1, 0);
    for (int c = 0; c < 40 && !drained(); c++) begin
      tests_run++;
      if (act_vec() !== exp_vec()) begin tests_failed++; $display("FAIL rr_cycle %0d: got %h expected %h", cyc, act_vec(), exp_vec()); end
      tick();
    end
    tests_run++;
    if (grant_log.size() != 5) begin tests_failed++; $display("FAIL rr_count: got %0d grants expected 5", grant_log.size()); end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (grant_log[k] != eo[k]) begin tests_failed++; $display("FAIL rr_order%0d: got %0d expected %0d", k, grant_log[k], eo[k]); end
    end
    for (int k = 1; k < 5; k++) begin
      tests_run++;
      if (wr_cyc[k] - wr_cyc[k-1] != 2) begin tests_failed++; $display("FAIL rr_bubble%0d: got spacing %0d expected 2", k, wr_cyc[k] - wr_cyc[k-1]); end
    end
  endtask

  task automatic test_full_backpressure();
    clear_logs();
    for (int k = 0; k < 6; k++) push_beat(2, 8'(8'h40 + k), (k == 5), 0);
    for (int c = 0; c < 20 && wr_dat.size() < 2; c++) begin
      tests_run++;
      if (act_vec() !== exp_vec()) begin tests_failed++; $display("FAIL full_pre_cycle %0d: got %h expected %h", cyc, act_vec(), exp_vec()); end
      tick();
    end
    full_next = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({fifo_w_en, req_ready, grant_id, busy} !== {1'b0, 4'b0000, 2'd2, 1'b1}) begin
        tests_failed++;
        $display("FAIL full_hold%0d: got w_en=%b ready=%b grant=%0d busy=%b expected 0 0000 2 1", k, fifo_w_en, req_ready, grant_id, busy);
      end
      if (k == 3) full_next = 1'b0;
      tick();
    end
    tests_run++;
    if (fifo_w_en !== 1'b1) begin tests_failed++; $display("FAIL full_resume: got w_en=%b expected 1", fifo_w_en); end
    for (int c = 0; c < 30 && !drained(); c++) begin
      tests_run++;
      if (act_vec() !== exp_vec()) begin tests_failed++; $display("FAIL full_cycle %0d: got %h expected %h", cyc, act_vec(), exp_vec()); end
      tick();
    end
    tests_run++;
    if (wr_dat.size() != 6) begin tests_failed++; $display("FAIL full_count: got %0d beats expected 6", wr_dat.size()); end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (wr_dat[k] !== 8'(8'h40 + k)) begin tests_failed++; $display("FAIL full_data%0d: got %h expected %h", k, wr_dat[k], 8'(8'h40 + k)); end
    end
  endtask

  task automatic test_drop_valid();
    int eg [6];
    int gap_cycles;
    eg = '{1, 1, 1, 1, 3, 3};
    gap_cycles = 0;
    do_reset();
    clear_logs();
    push_beat(1, 8'h61, 1'b0, 0);
    push_beat(1, 8'h62, 1'b0, 0);
    push_beat(1, 8'h63, 1'b0, 5);
    push_beat(1, 8'h64, 1'b1, 0);
    push_beat(3, 8'h81, 1'b0, 0);
    push_beat(3, 8'h82, 1'b1, 0);
    for (int c = 0; c < 40 && !drained(); c++) begin
      if (busy && grant_id == 2'd1 && !req_valid[1]) gap_cycles++;
      tests_run++;
      if (act_vec() !== exp_vec()) begin tests_failed++; $display("FAIL drop_cycle %0d: got %h expected %h", cyc, act_vec(), exp_vec()); end
      tick();
    end
    tests_run++;
    if (gap_cycles < 4) begin tests_failed++; $display("FAIL drop_hold: got %0d held idle cycles expected at least 4", gap_cycles); end
    tests_run++;
    if (!(grant_log.size() == 2 && grant_log[0] == 1 && grant_log[1] == 3)) begin
      tests_failed++; $display("FAIL drop_grants: got %0d grants (%0d,%0d) expected 2 (1,3)", grant_log.size(), grant_log[0], grant_log[1]);
    end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (wr_gid[k] != eg[k]) begin tests_failed++; $display("FAIL drop_order%0d: got id %0d expected %0d", k, wr_gid[k], eg[k]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int split;
    int n2;
    clear_logs();
    for (int k = 0; k < 5; k++) push_beat(2, 8'(8'hC0 + k), (k == 4), 0);
    for (int c = 0; c < 20 && wr_dat.size() < 2; c++) begin
      tests_run++;
      if (act_vec() !== exp_vec()) begin tests_failed++; $display("FAIL rstmid_pre_cycle %0d: got %h expected %h", cyc, act_vec(), exp_vec()); end
      tick();
    end
    rst = 1'b1;
    push_beat(1, 8'h99, 1'b1, 0);
    tick();
    rst = 1'b0;
    tests_run++;
    if ({busy, fifo_w_en} !== 2'b00) begin tests_failed++; $display("FAIL rstmid_after: got busy=%b w_en=%b expected 0 0", busy, fifo_w_en); end
    split = grant_log.size();
    for (int c = 0; c < 40 && !drained(); c++) begin
      tests_run++;
      if (act_vec() !== exp_vec()) begin tests_failed++; $display("FAIL rstmid_cycle %0d: got %h expected %h", cyc, act_vec(), exp_vec()); end
      tick();
    end
    tests_run++;
    if (!(grant_log.size() > split && grant_log[split] == 1)) begin
      tests_failed++; $display("FAIL rstmid_first_grant: got %0d expected 1", grant_log[split]);
    end
    n2 = 0;
    for (int k = 0; k < wr_gid.size(); k++) begin
      if (wr_gid[k] == 2) begin
        tests_run++;
        if (wr_dat[k] !== 8'(8'hC0 + n2)) begin tests_failed++; $display("FAIL rstmid_data%0d: got %h expected %h", n2, wr_dat[k], 8'(8'hC0 + n2)); end
        n2++;
      end
    end
    tests_run++;
    if (n2 != 5) begin tests_failed++; $display("FAIL rstmid_count: got %0d beats from req 2 expected 5", n2); end
  endtask

`ifdef FIFO_ARB_MAX_BURST_EN
  task automatic test_max_burst();
    int eg [5];
    int er [5];
    int runs[$];
    int run;
    eg = '{0, 1, 0, 1, 0};
    er = '{4, 1, 4, 1, 2};
    do_reset();
    clear_logs();
    push_burst(0, 10, 0);
    push_beat(1, 8'h71, 1'b1, 0);
    push_beat(1, 8'h72, 1'b1, 0);
    for (int c = 0; c < 60 && !drained(); c++) begin
      tests_run++;
      if (act_vec() !== exp_vec()) begin tests_failed++; $display("FAIL maxb_cycle %0d: got %h expected %h", cyc, act_vec(), exp_vec()); end
      tick();
    end
    run = 0;
    for (int k = 0; k < wr_gid.size(); k++) begin
      run++;
      if (k == wr_gid.size() - 1 || wr_gid[k+1] != wr_gid[k]) begin
        runs.push_back(run);
        run = 0;
      end
    end
    tests_run++;
    if (grant_log.size() != 5 || runs.size() != 5) begin
      tests_failed++; $display("FAIL maxb_count: got %0d grants %0d runs expected 5 5", grant_log.size(), runs.size());
    end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (grant_log[k] != eg[k] || runs[k] != er[k]) begin
        tests_failed++; $display("FAIL maxb_grant%0d: got id %0d with %0d beats expected id %0d with %0d beats", k, grant_log[k], runs[k], eg[k], er[k]);
      end
    end
  endtask
`endif

  task automatic test_random();
    int r;
    logic [7:0] e;
    clear_logs();
    for (int i = 0; i < N; i++) sb[i].delete();
    for (int c = 0; c < 3000; c++) begin
      tests_run++;
      if (act_vec() !== exp_vec()) begin tests_failed++; $display("FAIL random_cycle %0d: got %h expected %h", cyc, act_vec(), exp_vec()); end
      if ($urandom % 4 == 0) begin
        r = int'($urandom % N);
        if (q[r].size() < 6) push_burst(r, 1 + int'($urandom % 6), 3);
      end
      full_next = ($urandom % 5 == 0);
      tick();
    end
    full_next = 1'b0;
    for (int c = 0; c < 400 && !drained(); c++) begin
      tests_run++;
      if (act_vec() !== exp_vec()) begin tests_failed++; $display("FAIL random_drain_cycle %0d: got %h expected %h", cyc, act_vec(), exp_vec()); end
      tick();
    end
    tests_run++;
    if (!drained()) begin tests_failed++; $display("FAIL random_timeout: got pending traffic expected drained"); end
    for (int k = 0; k < wr_gid.size(); k++) begin
      e = sb[wr_gid[k]].pop_front();
      tests_run++;
      if (wr_dat[k] !== e) begin tests_failed++; $display("FAIL random_sb%0d: got %h from req %0d expected %h", k, wr_dat[k], wr_gid[k], e); end
    end
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (sb[i].size() != 0) begin tests_failed++; $display("FAIL random_lost_req%0d: got %0d unwritten beats expected 0", i, sb[i].size()); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_backpressure();
    test_drop_valid();
    test_reset_mid_burst();
`ifdef FIFO_ARB_MAX_BURST_EN
    test_max_burst();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
